// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, completion codes and common mouse commands.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side bus of the PS/2 host transmitter: byte request handshake, completion status and FSM state.
// Handshake: a byte transfers on a clock edge where iValid && oReady; oDone pulses once per accepted byte
// with oErr/oErrCode valid in that same cycle.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] iData;
  logic       iValid;
  logic       oReady;
  logic       oBusy;
  logic       oDone;
  logic       oErr;
  logic [1:0] oErrCode;
  ps2_state_e dbg_state;

  modport slave (
    input  iData, iValid,
    output oReady, oBusy, oDone, oErr, oErrCode, dbg_state
  );

  modport master (
    output iData, iValid,
    input  oReady, oBusy, oDone, oErr, oErrCode, dbg_state
  );

endinterface

// File: rtl/ps2_edge_sync.sv
// PS/2 pad synchroniser with falling-edge detect on ps2clk; shared with the mouse receiver.
// Define PS2_TX_CLK_FILTER_EN to add a FILTER_LEN-sample stability filter on the clock.
module ps2_edge_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_o,
  output logic data_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  logic       clk_lvl;

  // Reset to the idle-bus level so leaving reset never fakes a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_lvl;
    end
  end

`ifdef PS2_TX_CLK_FILTER_EN
  localparam int CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic            filt_q;
  logic [CntW-1:0] filt_cnt_q;

  // The level flips only once FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == CntW'(FILTER_LEN - 1)) begin
      filt_q     <= clk_sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign clk_lvl = filt_q;
`else
  assign clk_lvl = clk_sync_q[1];
`endif

  assign clk_o  = clk_lvl;
  assign data_o = data_sync_q[1];
  assign fall_o = clk_prev_q & ~clk_lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving ps2clk/ps2data open-drain via output enables.
// Optional clock glitch filter is enabled with PS2_TX_CLK_FILTER_EN (see ps2_edge_sync).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000,
  parameter int FILTER_LEN  = 4
) (
  input  logic          iBusClk,
  input  logic          iRstN,
  ps2_host_tx_if.slave  bus,
  input  logic          iPs2Clk,
  input  logic          iPs2Data,
  output logic          oPs2ClkOe,
  output logic          oPs2DataOe
);

  localparam int INH_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int INH_W   = (INH_CYC > 1) ? $clog2(INH_CYC) : 1;
  localparam int TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic clk_lvl;
  logic data_lvl;
  logic fall;

  ps2_edge_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_sync (
    .clk_i      (iBusClk),
    .rst_ni     (iRstN),
    .ps2_clk_i  (iPs2Clk),
    .ps2_data_i (iPs2Data),
    .clk_o      (clk_lvl),
    .data_o     (data_lvl),
    .fall_o     (fall)
  );

  ps2_state_e       state_q;
  logic [7:0]       shreg_q;
  logic             par_q;
  logic [3:0]       bit_cnt_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             nack_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic counting;
  logic to_hit;

  assign counting = (state_q == REQ) || (state_q == DATA) ||
                    (state_q == ACK) || (state_q == WAIT_IDLE);
  assign to_hit   = (to_cnt_q == TO_W'(TO_CYC - 1));

  always_ff @(posedge iBusClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      nack_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      if (counting) begin
        to_cnt_q <= fall ? '0 : to_cnt_q + 1'b1;
      end

      // A silent device wins over an edge landing in the same cycle.
      if (counting && to_hit) begin
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        done_q     <= 1'b1;
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        busy_q     <= 1'b0;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            if (bus.iValid && ready_q) begin
              shreg_q    <= bus.iData;
              par_q      <= odd_parity(bus.iData);
              clk_oe_q   <= 1'b1;
              inh_cnt_q  <= '0;
              nack_q     <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= ERR_NONE;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= INHIBIT;
            end
          end
          // ps2clk is held low for INH_CYC cycles; the start bit goes low on the last of them.
          INHIBIT: begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            if (inh_cnt_q == INH_W'(INH_CYC - 2)) begin
              data_oe_q <= 1'b1;
            end
            if (inh_cnt_q == INH_W'(INH_CYC - 1)) begin
              clk_oe_q <= 1'b0;
              state_q  <= REQ;
            end
          end
          REQ, DATA: begin
            if (fall) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              state_q   <= DATA;
              if (bit_cnt_q < 4'd8) begin
                data_oe_q <= ~shreg_q[0];
                shreg_q   <= {1'b0, shreg_q[7:1]};
              end else if (bit_cnt_q == 4'd8) begin
                data_oe_q <= ~par_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end
            end
          end
          ACK: begin
            if (fall) begin
              nack_q  <= data_lvl;
              state_q <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_lvl && data_lvl) begin
              done_q     <= 1'b1;
              err_q      <= nack_q;
              err_code_q <= nack_q ? ERR_NACK : ERR_NONE;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oPs2ClkOe     = clk_oe_q;
  assign oPs2DataOe    = data_oe_q;
  assign bus.oReady    = ready_q;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;
  assign bus.oErr      = err_q;
  assign bus.oErrCode  = err_code_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a 40-cycle-period device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic clk_oe;
  logic data_oe;
  logic ps2clk_line;
  logic ps2data_line;

  assign ps2clk_line  = dev_clk & ~clk_oe;
  assign ps2data_line = dev_data & ~data_oe;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .CLK_FREQ_HZ (1000000),
    .INHIBIT_US  (100),
    .TIMEOUT_US  (2000),
    .FILTER_LEN  (4)
  ) dut (
    .iBusClk    (clk),
    .iRstN      (rst_n),
    .bus        (bus),
    .iPs2Clk    (ps2clk_line),
    .iPs2Data   (ps2data_line),
    .oPs2ClkOe  (clk_oe),
    .oPs2DataOe (data_oe)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (bus.oDone === 1'b1) done_cnt++;

  // driver: one full transfer with the device model answering
  task automatic do_xfer(input logic [7:0] cmd, input bit ack, input bit poke, input bit glitch,
                         output int inh, output logic start_bit, output logic [7:0] rx,
                         output logic rx_par, output logic rx_stop, output bit got_done,
                         output logic d_err, output logic [1:0] d_code, output logic d_clkoe,
                         output logic d_dataoe, output logic rdy_at, output logic rdy_after);
    int g;
    g = 0;
    got_done = 0; d_err = 1'bx; d_code = 2'bxx; d_clkoe = 1'bx; d_dataoe = 1'bx; rdy_at = 1'bx;
    rx = 8'h00; rx_par = 1'bx; rx_stop = 1'bx;
    while (bus.oReady !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    bus.iData = cmd; bus.iValid = 1'b1;
    @(negedge clk);
    bus.iValid = 1'b0;
    inh = 0;
    while (clk_oe === 1'b1 && inh < 1000) begin
      inh++;
      if (poke && inh == 50) begin bus.iData = 8'h55; bus.iValid = 1'b1; end
      else bus.iValid = 1'b0;
      @(negedge clk);
    end
    bus.iValid = 1'b0;
    start_bit = ps2data_line;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k <= 8) rx[k-1] = ps2data_line;
      else if (k == 9) rx_par = ps2data_line;
      else rx_stop = ps2data_line;
      dev_clk = 1'b1;
      if (glitch && k == 4) begin
        repeat (8) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 10) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data = ack ? 1'b0 : 1'b1;
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    for (int t = 0; t < 200 && !got_done; t++) begin
      if (t == 2) dev_data = 1'b1;
      @(negedge clk);
      if (bus.oDone === 1'b1) begin
        got_done = 1; d_err = bus.oErr; d_code = bus.oErrCode;
        d_clkoe = clk_oe; d_dataoe = data_oe; rdy_at = bus.oReady;
      end
    end
    dev_data = 1'b1;
    @(negedge clk);
    rdy_after = bus.oReady;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.oReady); end
    checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.oBusy); end
    checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.oDone); end
    checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.oErr); end
    checks++; if (bus.oErrCode !== 2'b00) begin errors++; $display("FAIL reset_code got %b exp 00", bus.oErrCode); end
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b%b exp 00", clk_oe, data_oe); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.oReady !== 1'b1 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got rdy %b busy %b exp 1 0", bus.oReady, bus.oBusy); end
  endtask

  task automatic test_send_enable();
    int inh; logic sb, par, stp, e, ce, de, ra, rb; logic [7:0] rx; logic [1:0] c; bit dn;
    do_xfer(CMD_ENABLE, 1, 0, 0, inh, sb, rx, par, stp, dn, e, c, ce, de, ra, rb);
    checks++; if (inh !== 100) begin errors++; $display("FAIL f4_inhibit got %0d exp 100", inh); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL f4_start got %b exp 0", sb); end
    checks++; if (rx !== 8'hF4) begin errors++; $display("FAIL f4_byte got %h exp f4", rx); end
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL f4_parity got %b exp 0", par); end
    checks++; if (stp !== 1'b1) begin errors++; $display("FAIL f4_stop got %b exp 1", stp); end
    checks++; if (!dn) begin errors++; $display("FAIL f4_done got 0 exp 1"); end
    else begin
      checks++; if (e !== 1'b0 || c !== 2'b00) begin errors++; $display("FAIL f4_status got %b/%b exp 0/00", e, c); end
      checks++; if (ce !== 1'b0 || de !== 1'b0) begin errors++; $display("FAIL f4_oe got %b%b exp 00", ce, de); end
      checks++; if (ra !== 1'b0 || rb !== 1'b1) begin errors++; $display("FAIL f4_ready got %b then %b exp 0 then 1", ra, rb); end
    end
  endtask

  task automatic test_nack();
    int inh; logic sb, par, stp, e, ce, de, ra, rb; logic [7:0] rx; logic [1:0] c; bit dn;
    do_xfer(CMD_RESET, 0, 0, 0, inh, sb, rx, par, stp, dn, e, c, ce, de, ra, rb);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL ff_byte got %h exp ff", rx); end
    checks++; if (par !== 1'b1) begin errors++; $display("FAIL ff_parity got %b exp 1", par); end
    checks++; if (!dn) begin errors++; $display("FAIL ff_done got 0 exp 1"); end
    else begin
      checks++; if (e !== 1'b1 || c !== 2'b10) begin errors++; $display("FAIL ff_nack got %b/%b exp 1/10", e, c); end
    end
  endtask

  task automatic test_timeout();
    int g, n; bit dn;
    g = 0;
    while (bus.oReady !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    bus.iData = 8'hF4; bus.iValid = 1'b1;
    @(negedge clk);
    bus.iValid = 1'b0;
    g = 0;
    while (clk_oe === 1'b1 && g < 1000) begin @(negedge clk); g++; end
    n = 0; dn = 0;
    while (!dn && n < 3000) begin
      @(negedge clk); n++;
      if (bus.oDone === 1'b1) dn = 1;
    end
    checks++; if (!dn) begin errors++; $display("FAIL to_done got none exp pulse"); end
    else begin
      checks++; if (n !== 2000) begin errors++; $display("FAIL to_latency got %0d exp 2000", n); end
      checks++; if (bus.oErr !== 1'b1 || bus.oErrCode !== 2'b01) begin errors++; $display("FAIL to_status got %b/%b exp 1/01", bus.oErr, bus.oErrCode); end
      checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin errors++; $display("FAIL to_oe got %b%b exp 00", clk_oe, data_oe); end
      @(negedge clk);
      checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL to_ready got %b exp 1", bus.oReady); end
    end
  endtask

  task automatic test_ignore_busy();
    int inh; logic sb, par, stp, e, ce, de, ra, rb; logic [7:0] rx; logic [1:0] c; bit dn;
    do_xfer(8'hF4, 1, 1, 0, inh, sb, rx, par, stp, dn, e, c, ce, de, ra, rb);
    checks++; if (rx !== 8'hF4) begin errors++; $display("FAIL busy_poke_byte got %h exp f4", rx); end
    checks++; if (inh !== 100) begin errors++; $display("FAIL busy_poke_inhibit got %0d exp 100", inh); end
  endtask

  // scoreboard: expected bytes in order, compared as each transfer completes
  task automatic test_back_to_back();
    int inh; logic sb, par, stp, e, ce, de, ra, rb; logic [7:0] rx, exp_b; logic [1:0] c; bit dn;
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hF3);
    do_xfer(8'hF4, 1, 0, 0, inh, sb, rx, par, stp, dn, e, c, ce, de, ra, rb);
    exp_b = exp_q.pop_front();
    checks++; if (rx !== exp_b || !dn || e !== 1'b0) begin errors++; $display("FAIL b2b_first got %h done %0d err %b exp %h 1 0", rx, dn, e, exp_b); end
    do_xfer(8'hF3, 1, 0, 0, inh, sb, rx, par, stp, dn, e, c, ce, de, ra, rb);
    exp_b = exp_q.pop_front();
    checks++; if (rx !== exp_b || !dn || e !== 1'b0) begin errors++; $display("FAIL b2b_second got %h done %0d err %b exp %h 1 0", rx, dn, e, exp_b); end
    checks++; if (par !== 1'b1) begin errors++; $display("FAIL b2b_f3_parity got %b exp 1", par); end
  endtask

  task automatic test_reset_mid();
    int g, base;
    g = 0;
    while (bus.oReady !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    bus.iData = 8'hF4; bus.iValid = 1'b1;
    @(negedge clk);
    bus.iValid = 1'b0;
    g = 0;
    while (clk_oe === 1'b1 && g < 1000) begin @(negedge clk); g++; end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0; repeat (HALF) @(negedge clk);
      dev_clk = 1'b1; repeat (10) @(negedge clk);
    end
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL mid_bit4_drive got %b exp 1", data_oe); end
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin errors++; $display("FAIL mid_async_oe got %b%b exp 00", clk_oe, data_oe); end
    checks++; if (bus.oReady !== 1'b1 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL mid_async_rdy got %b busy %b exp 1 0", bus.oReady, bus.oBusy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL mid_after_ready got %b exp 1", bus.oReady); end
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL mid_no_done got %0d exp %0d", done_cnt, base); end
  endtask

`ifdef PS2_TX_CLK_FILTER_EN
  task automatic test_glitch();
    int inh; logic sb, par, stp, e, ce, de, ra, rb; logic [7:0] rx; logic [1:0] c; bit dn;
    do_xfer(8'hF4, 1, 0, 1, inh, sb, rx, par, stp, dn, e, c, ce, de, ra, rb);
    checks++; if (rx !== 8'hF4) begin errors++; $display("FAIL glitch_byte got %h exp f4", rx); end
    checks++; if (par !== 1'b0 || stp !== 1'b1) begin errors++; $display("FAIL glitch_frame got par %b stop %b exp 0 1", par, stp); end
    checks++; if (!dn || e !== 1'b0) begin errors++; $display("FAIL glitch_status got done %0d err %b exp 1 0", dn, e); end
  endtask
`endif

  initial begin
    bus.iData = 8'h00;
    bus.iValid = 1'b0;
    test_reset();
    test_send_enable();
    test_nack();
    test_timeout();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef PS2_TX_CLK_FILTER_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
